// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job arbiter slice.
//   - GCD engine datapath widths (operand, Bezout result, cycle count)
//   - engine op-code encoding
//   - arbiter FSM state encoding (3 bits)
package gcd_pkg;

  localparam int GCD_OP_W  = 1279;
  localparam int GCD_RES_W = 1284;
  localparam int GCD_CC_W  = 12;

  typedef enum logic [2:0] {
    GCD_OP_GCD    = 3'd0,
    GCD_OP_XGCD   = 3'd1,
    GCD_OP_MODINV = 3'd2,
    GCD_OP_CHECK  = 3'd3
  } gcd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_ARM    = 3'd3,
    ST_RUN    = 3'd4,
    ST_RESP   = 3'd5
  } arb_state_e;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester index this round (must be < NUM_REQ)
//   grant : one-hot grant, all zero when no request is pending
//   idx   : encoded index of the granted requester (0 when none)
module gcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  localparam int             SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] N_L   = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= N_L) cand = cand - N_L;
      if (!found && req[cand[SEL_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SEL_W-1:0]]  = 1'b1;
        idx                     = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one GCD engine among NUM_REQ requesters.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_debug_mode        : forwarded straight to the engine
//   req_*                 : per-requester job channel (flattened), req_ready one-hot in ARB
//   eng_*                 : engine launch fields (held ARB..RESP), start pulse, done/results
//   rsp_*                 : single response channel tagged with requester ID
//   busy                  : FSM not idle
//
// state  | meaning
// IDLE   | no job in flight, waiting for any req_valid
// ARB    | pick winner round-robin, handshake and latch its job
// LAUNCH | one-cycle eng_start pulse
// ARM    | skip one cycle so a stale eng_done from the last job is ignored
// RUN    | wait for eng_done or watchdog expiry
// RESP   | response held until rsp_ready
module gcd_job_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = GCD_OP_W,
  parameter int RES_W   = GCD_RES_W,
  parameter int TIMEOUT = 8191,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_debug_mode,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*3-1:0]    req_op_code,
  input  logic [NUM_REQ-1:0]      req_const_time,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    eng_start,
  output logic                    eng_clk_en,
  output logic                    eng_constant_time,
  output logic                    eng_debug_mode,
  output logic [2:0]              eng_op_code,
  output logic [OP_W-1:0]         eng_a,
  output logic [OP_W-1:0]         eng_b,
  input  logic                    eng_done,
  input  logic [GCD_CC_W-1:0]     eng_cycle_count,
  input  logic [RES_W-1:0]        eng_bezout_a,
  input  logic [RES_W-1:0]        eng_bezout_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_timeout,
  output logic [GCD_CC_W-1:0]     rsp_cycle_count,
  output logic [RES_W-1:0]        rsp_bezout_a,
  output logic [RES_W-1:0]        rsp_bezout_b,
  output logic                    busy
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] grant;
  logic [WD_W-1:0]    wd_q;
  logic               wd_hit;
  logic               any_req;
  logic [OP_W-1:0]    sel_a, sel_b;
  logic [2:0]         sel_op;
  logic               sel_ct;

  gcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  assign any_req        = |req_valid;
  assign wd_hit         = (wd_q == WD_W'(TIMEOUT - 1));
  assign req_ready      = (state_q == ST_ARB) ? grant : '0;
  assign eng_start      = (state_q == ST_LAUNCH);
  assign busy           = (state_q != ST_IDLE);
  assign eng_clk_en     = busy;
  assign rsp_valid      = (state_q == ST_RESP);
  assign eng_debug_mode = cfg_debug_mode;

  // Grant is one-hot, so an OR-mux of the granted slices selects the job.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_ct = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*OP_W +: OP_W];
        sel_b  = req_b[i*OP_W +: OP_W];
        sel_op = req_op_code[i*3 +: 3];
        sel_ct = req_const_time[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ARB;
      ST_ARB:    state_d = any_req ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_d = ST_ARM;
      ST_ARM:    state_d = ST_RUN;
      ST_RUN:    if (eng_done || wd_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = any_req ? ST_ARB : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Watchdog reads 0 during LAUNCH and counts every cycle after it, so expiry
  // lands RESP exactly TIMEOUT cycles after the LAUNCH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      rr_ptr_q          <= '0;
      wd_q              <= '0;
      rsp_id            <= '0;
      eng_a             <= '0;
      eng_b             <= '0;
      eng_op_code       <= '0;
      eng_constant_time <= 1'b0;
      rsp_timeout       <= 1'b0;
      rsp_cycle_count   <= '0;
      rsp_bezout_a      <= '0;
      rsp_bezout_b      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_ARB: begin
          if (any_req) begin
            eng_a             <= sel_a;
            eng_b             <= sel_b;
            eng_op_code       <= sel_op;
            eng_constant_time <= sel_ct;
            rsp_id            <= win_idx;
            rr_ptr_q          <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            wd_q              <= '0;
          end
        end
        ST_LAUNCH, ST_ARM: begin
          if (wd_q != '1) wd_q <= wd_q + WD_W'(1);
        end
        ST_RUN: begin
          if (wd_q != '1) wd_q <= wd_q + WD_W'(1);
          if (eng_done) begin
            rsp_timeout     <= 1'b0;
            rsp_cycle_count <= eng_cycle_count;
            rsp_bezout_a    <= eng_bezout_a;
            rsp_bezout_b    <= eng_bezout_b;
          end else if (wd_hit) begin
            rsp_timeout     <= 1'b1;
            rsp_cycle_count <= '0;
            rsp_bezout_a    <= '0;
            rsp_bezout_b    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Self-checking bench for gcd_job_arbiter with a behavioural engine stub.
// Stub: after eng_start it drops done after `stub_stale` cycles (0 = at start),
// raises done `stub_lat` cycles after start (0 = never) with
// bezout_a = a+b, bezout_b = a-b, cycle_count = min(lat, 0xFFF).
module tb_gcd_job_arbiter;

  localparam int N       = 4;
  localparam int OP_W    = 1279;
  localparam int RES_W   = 1284;
  localparam int TIMEOUT = 8191;
  localparam int ID_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n, cfg_debug_mode;
  logic [N-1:0]      req_valid, req_ready, req_const_time;
  logic [N*3-1:0]    req_op_code;
  logic [N*OP_W-1:0] req_a, req_b;
  logic              eng_start, eng_clk_en, eng_constant_time, eng_debug_mode;
  logic [2:0]        eng_op_code;
  logic [OP_W-1:0]   eng_a, eng_b;
  logic              eng_done;
  logic [11:0]       eng_cycle_count;
  logic [RES_W-1:0]  eng_bezout_a, eng_bezout_b;
  logic              rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [ID_W-1:0]   rsp_id;
  logic [11:0]       rsp_cycle_count;
  logic [RES_W-1:0]  rsp_bezout_a, rsp_bezout_b;

  logic [OP_W-1:0]   op_a [N];
  logic [OP_W-1:0]   op_b [N];
  logic [2:0]        opc  [N];
  logic [N-1:0]      ctv;

  int checks = 0, failures = 0;
  int ptr = 0;
  int n_start = 0;
  int stub_lat = 1, stub_stale = 0;
  int e_cnt;
  bit e_run;

  gcd_job_arbiter #(.NUM_REQ(N), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_debug_mode(cfg_debug_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_op_code(req_op_code),
    .req_const_time(req_const_time), .req_a(req_a), .req_b(req_b),
    .eng_start(eng_start), .eng_clk_en(eng_clk_en), .eng_constant_time(eng_constant_time),
    .eng_debug_mode(eng_debug_mode), .eng_op_code(eng_op_code), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_cycle_count(eng_cycle_count),
    .eng_bezout_a(eng_bezout_a), .eng_bezout_b(eng_bezout_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
    .rsp_cycle_count(rsp_cycle_count), .rsp_bezout_a(rsp_bezout_a), .rsp_bezout_b(rsp_bezout_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a       = '0;
    req_b       = '0;
    req_op_code = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*OP_W +: OP_W] = op_a[i];
      req_b[i*OP_W +: OP_W] = op_b[i];
      req_op_code[i*3 +: 3] = opc[i];
    end
  end
  assign req_const_time = ctv;

  always @(posedge clk) if (eng_start === 1'b1) n_start <= n_start + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_done        <= 1'b0;
      e_run           <= 1'b0;
      e_cnt           <= 0;
      eng_cycle_count <= '0;
      eng_bezout_a    <= '0;
      eng_bezout_b    <= '0;
    end else if (eng_start) begin
      e_run <= 1'b1;
      e_cnt <= 1;
      if (stub_stale == 0) eng_done <= 1'b0;
    end else if (e_run) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt == stub_stale) eng_done <= 1'b0;
      if (e_cnt == stub_lat) begin
        eng_done        <= 1'b1;
        e_run           <= 1'b0;
        eng_cycle_count <= (stub_lat > 4095) ? 12'hFFF : 12'(stub_lat);
        eng_bezout_a    <= RES_W'(eng_a) + RES_W'(eng_b);
        eng_bezout_b    <= RES_W'(eng_a) - RES_W'(eng_b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic rand_ops(input int i);
    logic [OP_W:0] t;
    for (int k = 0; k <= OP_W; k += 32) t[k +: 32] = $urandom();
    op_a[i] = t[OP_W-1:0];
    for (int k = 0; k <= OP_W; k += 32) t[k +: 32] = $urandom();
    op_b[i] = t[OP_W-1:0];
    opc[i]  = 3'($urandom_range(0, 7));
    ctv[i]  = 1'($urandom_range(0, 1));
  endtask

  // One job from ARB to response handshake, checked against the reference rules.
  task automatic run_job(input int lat, input int stale, input int hold, input logic [N-1:0] next_mask);
    int n, win, s0, exp_n, bad;
    bit tmo, ok;
    logic [OP_W-1:0]  ea, eb;
    logic [2:0]       eo;
    logic             ect;
    logic [RES_W-1:0] xa, xb;
    logic [11:0]      xc;
    stub_lat   = lat;
    stub_stale = stale;
    n = 0;
    while (req_ready === '0 && n < 8) begin tick(); n++; end
    chk("arb_reached", n < 8, 1);
    win = pick(req_valid, ptr);
    chk("grant", req_ready, (win < 0) ? 0 : (1 << win));
    if (win < 0) return;
    ea = op_a[win]; eb = op_b[win]; eo = opc[win]; ect = ctv[win];
    ptr   = (win + 1) % N;
    s0    = n_start;
    tmo   = (lat == 0) || (lat > TIMEOUT - 2);
    exp_n = tmo ? TIMEOUT + 1 : lat + 3;
    xa    = tmo ? '0 : RES_W'(ea) + RES_W'(eb);
    xb    = tmo ? '0 : RES_W'(ea) - RES_W'(eb);
    xc    = tmo ? 12'h0 : ((lat > 4095) ? 12'hFFF : 12'(lat));
    tick(); n = 1;
    chk("start_pulse", eng_start, 1);
    rand_ops(win);
    bad = 0;
    while (rsp_valid !== 1'b1 && n < TIMEOUT + 20) begin
      tick(); n++;
      if (req_ready !== '0 || eng_start !== 1'b0) bad++;
    end
    chk("resp_latency", n, exp_n);
    chk("no_ready_or_start_in_flight", bad, 0);
    chk("start_count", n_start - s0, 1);
    chk("rsp_id", rsp_id, win[ID_W-1:0]);
    chk("rsp_timeout", rsp_timeout, tmo);
    chk("rsp_cycle_count", rsp_cycle_count, xc);
    chk("rsp_bezout_a", rsp_bezout_a, xa);
    chk("rsp_bezout_b", rsp_bezout_b, xb);
    chk("eng_a_hold", eng_a, ea);
    chk("eng_b_hold", eng_b, eb);
    chk("eng_op_ct_hold", {eng_op_code, eng_constant_time}, {eo, ect});
    for (int h = 0; h < hold; h++) begin
      tick();
      ok = rsp_valid === 1'b1 && rsp_id === win[ID_W-1:0] && rsp_timeout === tmo &&
           rsp_cycle_count === xc && rsp_bezout_a === xa && rsp_bezout_b === xb &&
           req_ready === '0 && eng_start === 1'b0;
      chk("backpressure_stable", ok, 1);
    end
    req_valid = next_mask;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    if (next_mask != '0) chk("arb_after_resp", req_ready !== '0, 1);
    else                 chk("idle_after_resp", busy, 0);
  endtask

  initial begin
    int n, win, s0, silent;
    rst_n = 1'b0; cfg_debug_mode = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) rand_ops(i);
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_rsp_bezout_a", rsp_bezout_a, 0);
    rst_n = 1'b1;
    tick();

    // Fairness: all requesters held valid for 8 jobs.
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 12), 0, $urandom_range(0, 2), (j == 7) ? 4'h0 : 4'hF);

    // ARB with every valid withdrawn: back to IDLE, no launch, pointer untouched.
    s0 = n_start;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    #1;
    chk("drop_no_ready", req_ready, 0);
    tick();
    chk("drop_back_idle", busy, 0);
    chk("drop_no_start", n_start - s0, 0);

    // Single job: requester 0, A=15, B=6, engine takes 4098 cycles.
    op_a[0] = OP_W'(15); op_b[0] = OP_W'(6);
    req_valid = 4'b0001;
    run_job(4098, 0, 0, 4'b0100);

    // Backpressure for 20 cycles, next job already queued.
    run_job(5, 0, 20, 4'b0001);

    // Stale done held through LAUNCH/ARM, low 10 cycles in RUN, then high.
    run_job(11, 1, 1, 4'b0000);

    // Watchdog expiry, then done arriving exactly on the expiry cycle.
    req_valid = 4'b1000;
    run_job(0, 0, 3, 4'b0000);
    req_valid = 4'b0010;
    run_job(TIMEOUT - 2, 0, 0, 4'b0000);

    // Reset in the middle of RUN.
    req_valid  = 4'b0001;
    stub_lat   = 500;
    stub_stale = 0;
    n = 0;
    while (req_ready === '0 && n < 8) begin tick(); n++; end
    chk("rst_job_arb", n < 8, 1);
    win = pick(req_valid, ptr);
    ptr = (win + 1) % N;
    repeat (30) tick();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_clk_en", eng_clk_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_eng_start", eng_start, 0);
    chk("midrst_eng_a", eng_a, 0);
    chk("midrst_eng_op", {eng_op_code, eng_constant_time}, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_rsp_timeout", rsp_timeout, 0);
    rst_n = 1'b1;
    ptr = 0;
    silent = 0;
    repeat (600) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) silent++;
    end
    chk("no_resp_after_reset", silent, 0);
    req_valid = 4'b1001;
    run_job(7, 0, 0, 4'b0000);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      if (req_valid == '0) req_valid = 4'($urandom_range(1, 15));
      cfg_debug_mode = 1'($urandom_range(0, 1));
      #1;
      chk("debug_forward", eng_debug_mode, cfg_debug_mode);
      run_job($urandom_range(1, 40), $urandom_range(0, 1), $urandom_range(0, 3),
              4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
